// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU datapath and an external requester.
// The CPU wins up to CPU_WEIGHT back-to-back conflicts before EXT is forced through.
module dmem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned CPU_WEIGHT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_mem_read,
    input  logic          cpu_mem_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant_owner
);

    localparam logic [3:0] Weight = 4'(CPU_WEIGHT);

    logic [3:0]    conf_cnt_q, conf_cnt_d;
    logic          ext_ack_q, ext_ack_d;
    logic [DW-1:0] ext_rdata_q, ext_rdata_d;

    logic cpu_req, ext_elig, conflict, cpu_gnt, ext_gnt;

    // Grants are forced off while reset is held low.
    always_comb begin
        cpu_req  = cpu_mem_read | cpu_mem_write;
        ext_elig = ext_req & ~ext_ack_q;
        conflict = cpu_req & ext_elig;
        cpu_gnt  = 1'b0;
        ext_gnt  = 1'b0;
        if (rst) begin
            if (conflict) begin
                if (conf_cnt_q < Weight) cpu_gnt = 1'b1;
                else                     ext_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                ext_gnt = ext_elig;
            end
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_write = cpu_mem_write;
            mem_read  = cpu_mem_read & ~cpu_mem_write;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_write = ext_we;
            mem_read  = ~ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    always_comb begin
        cpu_rdata   = mem_rdata;
        cpu_stall   = cpu_req & ~cpu_gnt & rst;
        grant_owner = {ext_gnt, cpu_gnt};
        ext_ack     = ext_ack_q;
        ext_rdata   = ext_rdata_q;
    end

    always_comb begin
        conf_cnt_d  = conf_cnt_q;
        ext_ack_d   = ext_gnt;
        ext_rdata_d = ext_rdata_q;
        if (ext_gnt) begin
            conf_cnt_d = 4'd0;
            if (!ext_we) ext_rdata_d = mem_rdata;
        end else if (conflict && cpu_gnt && conf_cnt_q != 4'hF) begin
            conf_cnt_d = conf_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_cnt_q  <= 4'd0;
            ext_ack_q   <= 1'b0;
            ext_rdata_q <= '0;
        end else begin
            conf_cnt_q  <= conf_cnt_d;
            ext_ack_q   <= ext_ack_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: a per-cycle reference model predicts every output; a monitor compares.
module tb_dmem_arbiter;

    localparam int CPU_W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0, ext_rdata;
    logic        ext_ack;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant_owner;

    dmem_arbiter #(.AW(32), .DW(32), .CPU_WEIGHT(CPU_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_owner(grant_owner)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, write on rising edge.
    logic [31:0] mem [256];
    logic        mem_clr = 1'b1;
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    typedef struct packed {
        logic [1:0]  own;
        logic        mrd;
        logic        mwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] crd;
        logic        stall;
        logic        ack;
        logic [31:0] erd;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state
    logic [31:0] shadow [256];
    int          m_streak = 0;   // consecutive conflicts won by the CPU
    bit          m_ack = 0;
    logic [31:0] m_erd = '0;

    task automatic cycle(input bit r, input bit cr, input bit cw, input logic [31:0] ca,
                         input logic [31:0] cd, input bit er, input bit ew,
                         input logic [31:0] ea, input logic [31:0] ed, output bit egnt);
        obs_t e;
        bit   creq, elig;
        int   own;
        @(negedge clk);
        rst = r;
        cpu_mem_read = cr; cpu_mem_write = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
        if (!r) begin
            m_streak = 0; m_ack = 0; m_erd = '0;
        end
        creq = cr | cw;
        elig = er && !m_ack;
        if (!r)               own = 0;
        else if (creq && elig) own = (m_streak < CPU_W) ? 1 : 2;
        else if (creq)         own = 1;
        else if (elig)         own = 2;
        else                   own = 0;
        e = '0;
        e.own = 2'(own);
        if (own == 1) begin
            e.mwr = cw; e.mrd = cr && !cw; e.addr = ca; e.wdata = cd;
        end else if (own == 2) begin
            e.mwr = ew; e.mrd = !ew; e.addr = ea; e.wdata = ed;
        end
        e.crd   = shadow[e.addr[7:0]];
        e.stall = r && creq && own != 1;
        e.ack   = m_ack;
        e.erd   = m_erd;
        exp_q.push_back(e);
        if (r) begin
            if (own == 1) begin
                if (cw) shadow[ca[7:0]] = cd;
                if (elig && m_streak < 15) m_streak++;
            end else if (own == 2) begin
                m_streak = 0;
                if (ew) shadow[ea[7:0]] = ed;
                else    m_erd = shadow[ea[7:0]];
            end
            m_ack = (own == 2);
        end
        egnt = (own == 2);
    endtask

    // Monitor: checks the DUT mid-cycle, well away from the rising edge.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{own: grant_owner, mrd: mem_read, mwr: mem_write, addr: mem_addr,
                      wdata: mem_wdata, crd: cpu_rdata, stall: cpu_stall, ack: ext_ack,
                      erd: ext_rdata};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL vec%0d got own=%0d rd=%0b wr=%0b a=%h wd=%h crd=%h st=%0b ack=%0b erd=%h | want own=%0d rd=%0b wr=%0b a=%h wd=%h crd=%h st=%0b ack=%0b erd=%h",
                             n_vec, a.own, a.mrd, a.mwr, a.addr, a.wdata, a.crd, a.stall,
                             a.ack, a.erd, e.own, e.mrd, e.mwr, e.addr, e.wdata, e.crd,
                             e.stall, e.ack, e.erd);
                end
            end
        end
    end

    initial begin
        bit          g;
        int          ph;
        bit          er, ew;
        logic [31:0] ea, ed;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        repeat (2) @(posedge clk);
        mem_clr = 1'b0;

        // Held in reset with requests present: everything off
        cycle(0, 1, 1, 32'h44, 32'h1, 1, 1, 32'h48, 32'h2, g);
        // CPU store alone
        cycle(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, g);
        // EXT read alone, held through the ack cycle, then dropped
        cycle(1, 0, 0, 0, 0, 1, 0, 32'h10, 0, g);
        cycle(1, 0, 0, 0, 0, 1, 0, 32'h10, 0, g);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // Continuous CPU loads against a held EXT read
        for (int i = 0; i < 6; i++)
            cycle(1, 1, 0, 32'h10 + 32'(i), 0, i < 5, 0, 32'h10, 0, g);
        // Simultaneous read+write is a write, then read back
        cycle(1, 1, 1, 32'h20, 32'h5, 0, 0, 0, 0, g);
        cycle(1, 1, 0, 32'h20, 0, 0, 0, 0, 0, g);
        // EXT write granted, reset before its ack
        cycle(1, 0, 0, 0, 0, 1, 1, 32'h30, 32'hCAFE, g);
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h30, 32'hCAFE, g);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // Counter restarts at zero after release
        for (int i = 0; i < 6; i++)
            cycle(1, 0, 1, 32'h40, 32'(i), i < 5, 0, 32'h20, 0, g);
        // Idle bus
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // Randomized traffic obeying the EXT hold-until-ack protocol
        ph = 0; er = 0; ew = 0; ea = '0; ed = '0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) != 0);
            if (ph == 0) begin
                er = ($urandom_range(0, 2) != 0);
                ew = $urandom_range(0, 1) == 1;
                ea = $urandom;
                ed = $urandom;
            end
            cycle(r, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  $urandom, $urandom, er, ew, ea, ed, g);
            if (g)            ph = 2;
            else if (!r)      ph = 0;
            else if (ph == 2) ph = 0;
            else if (er)      ph = 1;
            else              ph = 0;
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #4;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
